// File: rtl/pipelined_multiplier_hs.sv
// rtl/pipelined_multiplier_hs.sv - parametrised signed/unsigned pipelined multiplier with valid/ready handshake
module pipelined_multiplier_hs #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int PW = 2 * WIDTH;
    localparam int NR = WIDTH + 1;

    typedef logic [PW-1:0]          row_t;
    typedef logic [NR-1:0][PW-1:0]  rows_t;

    function automatic int rows_left(int n0, int lv);
        int n = n0;
        for (int l = 0; l < lv; l++) begin
            if (n > 2) n = n - n / 3;
        end
        return n;
    endfunction

    function automatic int levels_total();
        int n = NR;
        int l = 0;
        while (n > 2) begin
            n = n - n / 3;
            l++;
        end
        return l;
    endfunction

    localparam int LT  = levels_total();
    localparam int MID = (STAGES > 2) ? STAGES - 2 : 1;
    localparam int LPS = (LT + MID - 1) / MID;

    // Signed mode: the multiplier MSB carries weight -2^(W-1), so its row is
    // negated as ~row plus a +1 correction row; everything wraps mod 2^(2W).
    function automatic rows_t gen_pp(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic sgn);
        rows_t r  = '0;
        row_t  xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        row_t  top;
        for (int i = 0; i < WIDTH - 1; i++) begin
            r[i] = y[i] ? (xe << i) : '0;
        end
        top = y[WIDTH-1] ? (xe << (WIDTH - 1)) : '0;
        if (sgn && y[WIDTH-1]) begin
            r[WIDTH-1] = ~top;
            r[WIDTH]   = row_t'(1);
        end else begin
            r[WIDTH-1] = top;
        end
        return r;
    endfunction

    // Up to lv levels of 3:2 compression on the first n0 rows; survivors are
    // packed to the low indices and unused rows are zero.
    function automatic rows_t csa_levels(rows_t r, int n0, int lv);
        rows_t cur = r;
        rows_t nxt;
        int    n   = n0;
        int    g3;
        for (int l = 0; l < lv; l++) begin
            if (n > 2) begin
                g3  = n / 3;
                nxt = '0;
                for (int g = 0; g < NR / 3; g++) begin
                    if (g < g3) begin
                        nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                        nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2])
                                     | (cur[3*g+1] & cur[3*g+2])) << 1;
                    end
                end
                for (int k = 0; k < NR; k++) begin
                    if (k >= 3 * g3 && k < n) nxt[k - g3] = cur[k];
                end
                cur = nxt;
                n   = n - g3;
            end
        end
        return cur;
    endfunction

    function automatic row_t finish_sum(rows_t r, int n0);
        rows_t f = csa_levels(r, n0, LT);
        return f[0] + f[1];
    endfunction

    logic                          stall;
    logic                          accept;
    logic [STAGES-1:0]             vld;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q;
    row_t                          prod_q;
    rows_t                         pp_in;

    assign stall     = vld[STAGES-1] && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && !stall;
    assign pp_in     = gen_pp(a, b, is_signed);

    assign out_valid = vld[STAGES-1];
    assign product   = prod_q;
    assign out_tag   = tag_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= '0;
            tag_q <= '0;
        end else if (!stall) begin
            vld[0] <= accept;
            if (accept) tag_q[0] <= in_tag;
            for (int s = 1; s < STAGES; s++) begin
                vld[s] <= vld[s-1];
                if (vld[s-1]) tag_q[s] <= tag_q[s-1];
            end
        end
    end

    if (STAGES == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_q <= '0;
            end else if (accept) begin
                prod_q <= finish_sum(pp_in, NR);
            end
        end
    end else begin : g_multi
        // pr[0] holds partial products, middle entries hold partially reduced rows.
        rows_t pr [STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < STAGES - 1; s++) pr[s] <= '0;
                prod_q <= '0;
            end else if (!stall) begin
                if (accept) pr[0] <= pp_in;
                for (int s = 1; s < STAGES - 1; s++) begin
                    if (vld[s-1]) pr[s] <= csa_levels(pr[s-1], rows_left(NR, (s - 1) * LPS), LPS);
                end
                if (vld[STAGES-2]) begin
                    prod_q <= finish_sum(pr[STAGES-2], rows_left(NR, (STAGES - 2) * LPS));
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_multiplier_hs.sv
// tb/tb_pipelined_multiplier_hs.sv - randomized self-checking bench for pipelined_multiplier_hs
module tb_pipelined_multiplier_hs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        m_in_valid, m_in_ready, m_is_signed, m_out_valid, m_out_ready;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_in_tag, m_out_tag;
    logic [63:0] m_product;

    logic        s_in_valid, s_in_ready, s_is_signed, s_out_valid, s_out_ready;
    logic [7:0]  s_a, s_b;
    logic [3:0]  s_in_tag, s_out_tag;
    logic [15:0] s_product;

    logic        d_in_valid, d_in_ready, d_is_signed, d_out_valid, d_out_ready;
    logic [15:0] d_a, d_b;
    logic [3:0]  d_in_tag, d_out_tag;
    logic [31:0] d_product;

    pipelined_multiplier_hs #(.WIDTH(32), .STAGES(3), .TAG_W(4)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .is_signed(m_is_signed), .in_tag(m_in_tag),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .product(m_product), .out_tag(m_out_tag));

    pipelined_multiplier_hs #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .is_signed(s_is_signed), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .product(s_product), .out_tag(s_out_tag));

    pipelined_multiplier_hs #(.WIDTH(16), .STAGES(5), .TAG_W(4)) u_deep (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .is_signed(d_is_signed), .in_tag(d_in_tag),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .product(d_product), .out_tag(d_out_tag));

    typedef struct {
        int          c;
        logic [63:0] p;
        logic [3:0]  t;
    } res_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    res_t got[$];
    logic seen_rdy, seen_v;
    logic [63:0] seen_p;
    logic [3:0]  seen_t;

    logic [31:0] t1_ops [5] = '{32'd11, 32'd111, 32'd1111, 32'd11111, 32'd111111};
    logic [63:0] t1_exp [5] = '{64'd121, 64'd12321, 64'd1234321, 64'd123454321, 64'd12345654321};
    logic [31:0] mm_a   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd91};
    logic [31:0] mm_b   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFB8};
    logic        mm_s   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] mm_exp [4] = '{64'hFFFFFFFE00000001, 64'd1, 64'h4000000000000000, 64'hFFFFFFFFFFFFE668};
    logic [63:0] bp_exp [4] = '{64'd6552, 64'd22, 64'd144, 64'd96};

    // Exact product of w-bit operands, as plain integer arithmetic modulo 2^(2w).
    function automatic logic [63:0] ref_mul(int w, logic [31:0] x, logic [31:0] y, logic sg);
        longint      sx = longint'({32'b0, x});
        longint      sy = longint'({32'b0, y});
        logic [63:0] p;
        if (sg && x[w-1]) sx = sx - (longint'(1) << w);
        if (sg && y[w-1]) sy = sy - (longint'(1) << w);
        p = 64'(sx * sy);
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    function automatic logic [31:0] pick(int w);
        logic [31:0] mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return mask;
            2: return 32'd1 << (w - 1);
            3: return 32'd1;
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic sg, input logic [3:0] t, input logic ordy);
        m_in_valid  = v;
        m_a         = x;
        m_b         = y;
        m_is_signed = sg;
        m_in_tag    = t;
        m_out_ready = ordy;
        #1;
        seen_rdy = m_in_ready;
        seen_v   = m_out_valid;
        seen_p   = m_product;
        seen_t   = m_out_tag;
        if (m_out_valid && m_out_ready) got.push_back('{cyc, m_product, m_out_tag});
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_in_valid = 0; m_a = 0; m_b = 0; m_is_signed = 0; m_in_tag = 0; m_out_ready = 1;
        s_in_valid = 0; s_a = 0; s_b = 0; s_is_signed = 0; s_in_tag = 0; s_out_ready = 1;
        d_in_valid = 0; d_a = 0; d_b = 0; d_is_signed = 0; d_in_tag = 0; d_out_ready = 1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({m_out_valid, m_product, m_out_tag} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%0d p=%h t=%h, need all zero", m_out_valid, m_product, m_out_tag);
        end
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %0d, need 1", m_in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({s_out_valid, d_out_valid, s_product, d_product} !== 50'd0) begin
            n_err++;
            $display("FAIL reset_sweep_outputs: got sv=%0d dv=%0d sp=%h dp=%h, need zero",
                     s_out_valid, d_out_valid, s_product, d_product);
        end
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic test_sequence();
        int base = cyc;
        got.delete();
        for (int k = 0; k < 5; k++) drive(1, t1_ops[k], t1_ops[k], 0, 4'(k), 1);
        repeat (6) drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (got.size() != 5) begin
            n_err++;
            $display("FAIL seq_count: got %0d results, need 5", got.size());
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_vec++;
            if (got[i].p !== t1_exp[i] || got[i].t !== 4'(i) || got[i].c != base + i + 3) begin
                n_err++;
                $display("FAIL seq_result%0d: got p=%0d t=%0d cyc=%0d, need p=%0d t=%0d cyc=%0d",
                         i, got[i].p, got[i].t, got[i].c, t1_exp[i], i, base + i + 3);
            end
        end
    endtask

    task automatic test_mode_mix();
        int base = cyc;
        got.delete();
        for (int k = 0; k < 4; k++) drive(1, mm_a[k], mm_b[k], mm_s[k], 4'(8 + k), 1);
        repeat (5) drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (got.size() != 4) begin
            n_err++;
            $display("FAIL mode_count: got %0d results, need 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_vec++;
            if (got[i].p !== mm_exp[i] || got[i].t !== 4'(8 + i) || got[i].c != base + i + 3) begin
                n_err++;
                $display("FAIL mode_result%0d: got p=%h t=%0d cyc=%0d, need p=%h t=%0d cyc=%0d",
                         i, got[i].p, got[i].t, got[i].c, mm_exp[i], 8 + i, base + i + 3);
            end
        end
    endtask

    task automatic test_backpressure();
        int base = cyc;
        got.delete();
        drive(1, 91, 72, 0, 1, 0);
        drive(1, 1, 22, 0, 2, 0);
        drive(1, 12, 12, 0, 3, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 99, 99, 0, 4'd15, 0);
            n_vec++;
            if (seen_rdy !== 1'b0 || seen_v !== 1'b1 || seen_p !== 64'd6552) begin
                n_err++;
                $display("FAIL stall_hold%0d: got rdy=%0d v=%0d p=%0d, need rdy=0 v=1 p=6552",
                         i, seen_rdy, seen_v, seen_p);
            end
        end
        drive(1, 48, 2, 0, 4, 1);
        repeat (7) drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (got.size() != 4) begin
            n_err++;
            $display("FAIL stall_count: got %0d results, need 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_vec++;
            if (got[i].p !== bp_exp[i] || got[i].t !== 4'(i + 1) || got[i].c != base + 8 + i) begin
                n_err++;
                $display("FAIL stall_result%0d: got p=%0d t=%0d cyc=%0d, need p=%0d t=%0d cyc=%0d",
                         i, got[i].p, got[i].t, got[i].c, bp_exp[i], i + 1, base + 8 + i);
            end
        end
    endtask

    task automatic test_bubbles();
        int base = cyc;
        got.delete();
        drive(1, 2, 3, 0, 5, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 4, 5, 0, 6, 1);
        drive(0, 0, 0, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (got.size() != 2) begin
            n_err++;
            $display("FAIL bubble_count: got %0d results, need 2", got.size());
        end else begin
            n_vec++;
            if (got[0].p !== 64'd6 || got[0].t !== 4'd5 || got[0].c != base + 3) begin
                n_err++;
                $display("FAIL bubble_first: got p=%0d t=%0d cyc=%0d, need p=6 t=5 cyc=%0d",
                         got[0].p, got[0].t, got[0].c, base + 3);
            end
            n_vec++;
            if (got[1].p !== 64'd20 || got[1].t !== 4'd6 || got[1].c != base + 5) begin
                n_err++;
                $display("FAIL bubble_second: got p=%0d t=%0d cyc=%0d, need p=20 t=6 cyc=%0d",
                         got[1].p, got[1].t, got[1].c, base + 5);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        drive(1, 3, 5, 0, 5, 1);
        drive(1, 4, 4, 0, 6, 1);
        drive(1, 9, 9, 0, 7, 1);
        n_vec++;
        if (m_out_valid !== 1'b1 || m_product !== 64'd15) begin
            n_err++;
            $display("FAIL rst_mid_before: got v=%0d p=%0d, need v=1 p=15", m_out_valid, m_product);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (m_out_valid !== 1'b0 || m_product !== 64'd0 || m_out_tag !== 4'd0) begin
            n_err++;
            $display("FAIL rst_mid_clear: got v=%0d p=%0d t=%0d, need all 0", m_out_valid, m_product, m_out_tag);
        end
        #1;
        rst_n = 1'b1;
        got.delete();
        repeat (6) drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_discard: got %0d results after reset, need 0", got.size());
        end
        got.delete();
        base = cyc;
        drive(1, 7, 6, 0, 9, 1);
        repeat (5) drive(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (got.size() != 1 || got[0].p !== 64'd42 || got[0].t !== 4'd9 || got[0].c != base + 3) begin
            n_err++;
            $display("FAIL rst_mid_after: got n=%0d, need one result p=42 t=9 cyc=%0d", got.size(), base + 3);
        end
    endtask

    task automatic test_random_backpressure();
        logic        mv [3] = '{0, 0, 0};
        logic [63:0] mp [3];
        logic [3:0]  mt [3];
        logic        v, sg, ordy, exp_stall;
        logic [31:0] x, y;
        logic [3:0]  t;
        for (int i = 0; i < 250; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            sg   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            x    = pick(32);
            y    = pick(32);
            t    = 4'($urandom_range(0, 15));
            drive(v, x, y, sg, t, ordy);
            exp_stall = mv[2] && !ordy;
            n_vec++;
            if (seen_rdy !== !exp_stall || seen_v !== mv[2]) begin
                n_err++;
                $display("FAIL rand_hs%0d: got rdy=%0d v=%0d, need rdy=%0d v=%0d",
                         i, seen_rdy, seen_v, !exp_stall, mv[2]);
            end
            if (mv[2]) begin
                n_vec++;
                if (seen_p !== mp[2] || seen_t !== mt[2]) begin
                    n_err++;
                    $display("FAIL rand_data%0d: got p=%h t=%0d, need p=%h t=%0d", i, seen_p, seen_t, mp[2], mt[2]);
                end
            end
            if (!exp_stall) begin
                mv[2] = mv[1]; mp[2] = mp[1]; mt[2] = mt[1];
                mv[1] = mv[0]; mp[1] = mp[0]; mt[1] = mt[0];
                mv[0] = v;     mp[0] = ref_mul(32, x, y, sg); mt[0] = t;
            end
        end
        m_in_valid  = 0;
        m_out_ready = 1;
    endtask

    task automatic test_param_sweep();
        res_t sq[$];
        res_t dq[$];
        res_t e;
        logic exp_v;
        logic [31:0] x, y;
        logic sg, v;
        logic [3:0] t;
        for (int i = 0; i < 320; i++) begin
            v = (i < 300) && ($urandom_range(0, 3) != 0);
            x = pick(8); y = pick(8); sg = 1'($urandom_range(0, 1)); t = 4'($urandom_range(0, 15));
            s_in_valid = v; s_a = x[7:0]; s_b = y[7:0]; s_is_signed = sg; s_in_tag = t;
            if (v) sq.push_back('{cyc + 1, ref_mul(8, x, y, sg), t});
            v = (i < 300) && ($urandom_range(0, 3) != 0);
            x = pick(16); y = pick(16); sg = 1'($urandom_range(0, 1)); t = 4'($urandom_range(0, 15));
            d_in_valid = v; d_a = x[15:0]; d_b = y[15:0]; d_is_signed = sg; d_in_tag = t;
            if (v) dq.push_back('{cyc + 5, ref_mul(16, x, y, sg), t});
            #1;
            n_vec++;
            if (s_in_ready !== 1'b1 || d_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL sweep_ready%0d: got s=%0d d=%0d, need 1 1", i, s_in_ready, d_in_ready);
            end
            exp_v = (sq.size() > 0 && sq[0].c == cyc);
            n_vec++;
            if (s_out_valid !== exp_v) begin
                n_err++;
                $display("FAIL sweep8_valid%0d: got %0d, need %0d", i, s_out_valid, exp_v);
            end
            if (exp_v) begin
                e = sq.pop_front();
                n_vec++;
                if (s_product !== e.p[15:0] || s_out_tag !== e.t) begin
                    n_err++;
                    $display("FAIL sweep8_data%0d: got p=%h t=%0d, need p=%h t=%0d", i, s_product, s_out_tag, e.p[15:0], e.t);
                end
            end
            exp_v = (dq.size() > 0 && dq[0].c == cyc);
            n_vec++;
            if (d_out_valid !== exp_v) begin
                n_err++;
                $display("FAIL sweep16_valid%0d: got %0d, need %0d", i, d_out_valid, exp_v);
            end
            if (exp_v) begin
                e = dq.pop_front();
                n_vec++;
                if (d_product !== e.p[31:0] || d_out_tag !== e.t) begin
                    n_err++;
                    $display("FAIL sweep16_data%0d: got p=%h t=%0d, need p=%h t=%0d", i, d_product, d_out_tag, e.p[31:0], e.t);
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (sq.size() != 0 || dq.size() != 0) begin
            n_err++;
            $display("FAIL sweep_drain: got %0d/%0d results outstanding, need 0/0", sq.size(), dq.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequence();
        test_mode_mix();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random_backpressure();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_multiplier_hs.md
Name: pipelined_multiplier_hs

Overview:
- Parametrised successor to the fixed 32x32 pipelined Wallace-tree multiplier.
- Configurable operand width and pipeline depth.
- Per-operation signed/unsigned mode and a sideband tag.
- Valid/ready handshake on input and output, with full backpressure.
- Sits between operand producers (ALU/DSP datapath) and a result consumer that may stall.

Parameters:
WIDTH, 32, operand width in bits (>=4)
STAGES, 3, pipeline register stages from input acceptance to result (>=1)
TAG_W, 4, width of sideband tag carried alongside each operation (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair present
in_ready  output  1  block can accept an operand pair this cycle
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands, 0 = unsigned
in_tag  input  TAG_W  opaque tag, returned with the result
out_valid  output  1  product/out_tag valid
out_ready  input  1  consumer accepts the result this cycle
product  output  2*WIDTH  full-width product
out_tag  output  TAG_W  tag of the operation whose product is shown

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear immediately; out_valid=0, product=0, out_tag=0. Internal data registers are cleared to 0. in_ready=1 while in reset-released idle. In-flight operations are discarded and never emerge.
- Accept: an operation enters when in_valid && in_ready at a rising edge. Captured values are a, b, is_signed and in_tag.
- Stall condition: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational from out_valid and out_ready).
  - During stall, every stage holds (global enable = !stall). product, out_tag and out_valid are stable.
  - in_valid is ignored during stall.
- Latency: with no stall, a result accepted at edge N is presented (out_valid=1) after edge N+STAGES-1, i.e. visible for the cycle following the STAGES-th edge counting the capture edge. Example: STAGES=3 means the result appears 3 cycles after acceptance. Stall cycles add exactly one cycle each.
- Throughput: one operation per cycle when out_ready stays high. Results are strictly in acceptance order; no reordering or loss.
- Bubbles: cycles without acceptance propagate as invalid stages. out_valid=0 for those slots.
- Output transfer: occurs when out_valid && out_ready. The next stage contents advance the same edge.
- Arithmetic:
  - Unsigned: product = a*b, exact, 2*WIDTH bits.
  - Signed: operands are two's complement and product is the exact two's-complement 2*WIDTH result.
  - Corner case: min*min = 2^(2*WIDTH-2), which must not overflow.
  - Mode is latched per operation; mixed signed/unsigned streams are legal back to back.
- Structure:
  - Partial-product generation in the first stage.
  - Carry-save (Wallace/Dadda) reduction distributed across the middle stages.
  - Final carry-propagate add in the last stage.
  - With STAGES=1, the full product is computed combinationally and registered once.
  - Internal split is free, but latency must match STAGES exactly.
- Combinational paths: only in_ready depends combinationally on out_ready/out_valid. No other input-to-output combinational path exists.

Test Plan:
1. Defaults, out_ready=1. Send unsigned (11,11), then back-to-back (111,111), (1111,1111), (11111,11111), (111111,111111) with tags 0..4 -> products 121, 12321, 1234321, 123454321, 12345654321 appear on consecutive cycles, first exactly 3 cycles after acceptance, tags 0..4 in order.
2. Mode mix back to back: unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001; signed 0xFFFFFFFF*0xFFFFFFFF (-1*-1) -> 1; signed 0x80000000*0x80000000 -> 0x4000000000000000; signed 91*-72 -> -6552 (0xFFFFFFFFFFFFE668).
3. Backpressure: fill pipeline with (91,72),(1,22),(12,12),(48,2), then drop out_ready for 5 cycles. Required: in_ready=0 throughout, product stays 6552, offered inputs are not captured. On release, 6552, 22, 144, 96 emerge in order with no duplicates.
4. Bubbles: in_valid toggled 1,0,1,0 with (2,3),(4,5) -> out_valid pattern 1,0,1 with products 6 and 20 at the correct latency.
5. Reset mid-operation: 3 operations in flight, pulse rst_n low between edges -> out_valid, product and out_tag go to 0 immediately. Nothing emerges after release, and a new (7,6) yields 42 at normal latency.
6. Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=16/STAGES=5 with random signed/unsigned operands against a reference model -> all products exact, latencies 1 and 5 respectively.
